// File: rtl/clock_reset_sequencer.sv
// +----------------------------------------------------------------------------+
// | clock_reset_sequencer: ordered interconnect/peripheral reset release for   |
// | one clock domain. Optional ext-request debounce: CLOCK_RESET_SEQ_DEBOUNCE_EN|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module clock_reset_sequencer #(
  parameter int IC_HOLD_CYCLES      = 16,
  parameter int PERIPH_DELAY_CYCLES = 8,
  parameter int DEBOUNCE_CYCLES     = 4,
  parameter int CNT_W               = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ext_reset_req,
  input  logic       i_clk_locked,
  input  logic       i_sw_reset,
  output logic       o_interconnect_reset,
  output logic       o_interconnect_resetn,
  output logic       o_peripheral_reset,
  output logic       o_peripheral_resetn,
  output logic       o_reset_done,
  output logic [1:0] o_state
);

  localparam logic [1:0] S_HOLD   = 2'd0;
  localparam logic [1:0] S_REL_IC = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;

  localparam logic [CNT_W-1:0] c_IC_LAST = CNT_W'(IC_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_PD_LAST = CNT_W'(PERIPH_DELAY_CYCLES - 1);

  if ((IC_HOLD_CYCLES < 1) || (IC_HOLD_CYCLES >= (2 ** CNT_W)) ||
      (PERIPH_DELAY_CYCLES < 1) || (PERIPH_DELAY_CYCLES >= (2 ** CNT_W)) ||
      (DEBOUNCE_CYCLES < 1)) begin : g_bad_params
    $error("clock_reset_sequencer: parameter out of range");
  end

  logic             r_ext_meta;
  logic             r_ext_sync;
  logic             r_lock_meta;
  logic             r_lock_sync;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ic_rst;
  logic             r_ic_rstn;
  logic             r_pr_rst;
  logic             r_pr_rstn;
  logic             r_done;

  logic             w_ext_eff;
  logic             w_trigger;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Reset values keep the block in reset until the real inputs propagate.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ext_meta  <= 1'b1;
      r_ext_sync  <= 1'b1;
      r_lock_meta <= 1'b0;
      r_lock_sync <= 1'b0;
    end else begin
      r_ext_meta  <= i_ext_reset_req;
      r_ext_sync  <= r_ext_meta;
      r_lock_meta <= i_clk_locked;
      r_lock_sync <= r_lock_meta;
    end
  end

`ifdef CLOCK_RESET_SEQ_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] c_DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

  // Counts prior consecutive high cycles, saturating; starts saturated so
  // the request is effective straight out of reset.
  logic [DB_W-1:0] r_db_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_db_cnt <= c_DB_MAX;
    end else if (!r_ext_sync) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt != c_DB_MAX) begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  assign w_ext_eff = r_ext_sync && (r_db_cnt == c_DB_MAX);
`else
  assign w_ext_eff = r_ext_sync;
`endif

  assign w_trigger = w_ext_eff | ~r_lock_sync | i_sw_reset;

  // Trigger is tested first in every state so it beats count-complete.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_HOLD: begin
        if (w_trigger) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == c_IC_LAST) begin
          w_state_nxt = S_REL_IC;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_REL_IC: begin
        if (w_trigger) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_PD_LAST) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (w_trigger) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_HOLD;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from next-state so they move with the state flop.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_HOLD;
      r_cnt     <= '0;
      r_ic_rst  <= 1'b1;
      r_ic_rstn <= 1'b0;
      r_pr_rst  <= 1'b1;
      r_pr_rstn <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ic_rst  <= (w_state_nxt == S_HOLD);
      r_ic_rstn <= (w_state_nxt != S_HOLD);
      r_pr_rst  <= (w_state_nxt != S_RUN);
      r_pr_rstn <= (w_state_nxt == S_RUN);
      r_done    <= (w_state_nxt == S_RUN);
    end
  end

  assign o_interconnect_reset  = r_ic_rst;
  assign o_interconnect_resetn = r_ic_rstn;
  assign o_peripheral_reset    = r_pr_rst;
  assign o_peripheral_resetn   = r_pr_rstn;
  assign o_reset_done          = r_done;
  assign o_state               = r_state;

endmodule

`default_nettype wire

// File: tb/tb_clock_reset_sequencer.sv
// Testbench for clock_reset_sequencer: edge-indexed expected outputs are
// queued per scenario and popped one per clock edge.
`default_nettype none

module tb_clock_reset_sequencer;

  localparam int IC = 16;
  localparam int PD = 8;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_ext_reset_req = 1'b0;
  logic       i_clk_locked = 1'b1;
  logic       i_sw_reset = 1'b0;
  logic       o_interconnect_reset;
  logic       o_interconnect_resetn;
  logic       o_peripheral_reset;
  logic       o_peripheral_resetn;
  logic       o_reset_done;
  logic [1:0] o_state;

  clock_reset_sequencer #(
    .IC_HOLD_CYCLES(IC),
    .PERIPH_DELAY_CYCLES(PD),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(8)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_ext_reset_req(i_ext_reset_req),
    .i_clk_locked(i_clk_locked),
    .i_sw_reset(i_sw_reset),
    .o_interconnect_reset(o_interconnect_reset),
    .o_interconnect_resetn(o_interconnect_resetn),
    .o_peripheral_reset(o_peripheral_reset),
    .o_peripheral_resetn(o_peripheral_resetn),
    .o_reset_done(o_reset_done),
    .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int         e;
    logic [6:0] v;
  } exp_t;

  exp_t       sb[$];
  exp_t       x;
  logic [6:0] obs;
  int         checks = 0;
  int         errors = 0;
  int         nxt = 0;

  // {ic_rst, ic_rstn, pr_rst, pr_rstn, done, state}
  function automatic logic [6:0] expv(input logic [1:0] st);
    logic ic;
    logic pr;
    ic = (st == 2'd0);
    pr = (st != 2'd2);
    return {ic, ~ic, pr, ~pr, (st == 2'd2), st};
  endfunction

  // Expected state at edge e once a trigger took effect at edge t.
  function automatic logic [1:0] seq_state(input int e, input int t);
    if (e <= t + IC) return 2'd0;
    if (e <= t + IC + PD) return 2'd1;
    return 2'd2;
  endfunction

  task automatic push(input int e, input logic [1:0] st);
    exp_t p;
    p.e = e;
    p.v = expv(st);
    sb.push_back(p);
  endtask

  task automatic step();
    @(posedge i_clk);
    nxt++;
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step();
    push(-1, 2'd0);
    x = sb.pop_front();
    obs = {o_interconnect_reset, o_interconnect_resetn, o_peripheral_reset,
           o_peripheral_resetn, o_reset_done, o_state};
    checks++;
    if (obs !== x.v) begin
      errors++;
      $display("FAIL reset_state: got %b expected %b", obs, x.v);
    end
    i_reset = 1'b0;
    nxt = 0;
  endtask

  task automatic test_powerup();
    for (int e = 0; e <= 39; e++) push(e, seq_state(e, 1));
    while (sb.size() > 0) begin
      x = sb.pop_front();
      obs = {o_interconnect_reset, o_interconnect_resetn, o_peripheral_reset,
             o_peripheral_resetn, o_reset_done, o_state};
      checks++;
      if (obs !== x.v) begin
        errors++;
        $display("FAIL powerup edge %0d: got %b expected %b", x.e, obs, x.v);
      end
      step();
    end
  endtask

  task automatic test_sw_reset();
    push(40, 2'd2);
    for (int e = 41; e <= 70; e++) push(e, seq_state(e, 40));
    while (sb.size() > 0) begin
      x = sb.pop_front();
      obs = {o_interconnect_reset, o_interconnect_resetn, o_peripheral_reset,
             o_peripheral_resetn, o_reset_done, o_state};
      checks++;
      if (obs !== x.v) begin
        errors++;
        $display("FAIL sw_reset edge %0d: got %b expected %b", x.e, obs, x.v);
      end
      i_sw_reset = (nxt == 40);
      step();
    end
    i_sw_reset = 1'b0;
  endtask

  task automatic test_lock_glitch();
    push(71, 2'd2);
    for (int e = 72; e <= 92; e++) push(e, seq_state(e, 71));
    for (int e = 93; e <= 120; e++) push(e, seq_state(e, 92));
    while (sb.size() > 0) begin
      x = sb.pop_front();
      obs = {o_interconnect_reset, o_interconnect_resetn, o_peripheral_reset,
             o_peripheral_resetn, o_reset_done, o_state};
      checks++;
      if (obs !== x.v) begin
        errors++;
        $display("FAIL lock_glitch edge %0d: got %b expected %b", x.e, obs, x.v);
      end
      i_sw_reset   = (nxt == 71);
      i_clk_locked = (nxt != 90);
      step();
    end
    i_sw_reset   = 1'b0;
    i_clk_locked = 1'b1;
  endtask

  task automatic test_priority();
    push(121, 2'd2);
    for (int e = 122; e <= 137; e++) push(e, seq_state(e, 121));
    for (int e = 138; e <= 165; e++) push(e, seq_state(e, 137));
    while (sb.size() > 0) begin
      x = sb.pop_front();
      obs = {o_interconnect_reset, o_interconnect_resetn, o_peripheral_reset,
             o_peripheral_resetn, o_reset_done, o_state};
      checks++;
      if (obs !== x.v) begin
        errors++;
        $display("FAIL trigger_priority edge %0d: got %b expected %b", x.e, obs, x.v);
      end
      i_sw_reset = (nxt == 121) || (nxt == 137);
      step();
    end
    i_sw_reset = 1'b0;
  endtask

  task automatic test_reset_in_run();
    push(166, 2'd2);
    for (int e = 167; e <= 197; e++) push(e, seq_state(e, 169));
    while (sb.size() > 0) begin
      x = sb.pop_front();
      obs = {o_interconnect_reset, o_interconnect_resetn, o_peripheral_reset,
             o_peripheral_resetn, o_reset_done, o_state};
      checks++;
      if (obs !== x.v) begin
        errors++;
        $display("FAIL reset_in_run edge %0d: got %b expected %b", x.e, obs, x.v);
      end
      i_reset = (nxt == 166) || (nxt == 167);
      step();
    end
    i_reset = 1'b0;
  endtask

  task automatic test_ext_req();
`ifdef CLOCK_RESET_SEQ_DEBOUNCE_EN
    for (int e = 198; e <= 230; e++) push(e, 2'd2);
`else
    for (int e = 198; e <= 200; e++) push(e, 2'd2);
    for (int e = 201; e <= 230; e++) push(e, seq_state(e, 201));
`endif
    while (sb.size() > 0) begin
      x = sb.pop_front();
      obs = {o_interconnect_reset, o_interconnect_resetn, o_peripheral_reset,
             o_peripheral_resetn, o_reset_done, o_state};
      checks++;
      if (obs !== x.v) begin
        errors++;
        $display("FAIL ext_req edge %0d: got %b expected %b", x.e, obs, x.v);
      end
      i_ext_reset_req = (nxt == 198) || (nxt == 199);
      step();
    end
    i_ext_reset_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_sw_reset();
    test_lock_glitch();
    test_priority();
    test_reset_in_run();
    test_ext_req();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/clock_reset_sequencer.md
# clock_reset_sequencer

Generates the per-domain reset set (peripheral and interconnect, both polarities) for one clock domain. It feeds one domain's reset inputs of the clocks/resets slave bridge. It synchronises an external reset request and a clock-locked indication, and accepts a host software reset pulse. Resets are released in order: interconnect first, then peripherals, with programmable hold times.

## Interface
- IC_HOLD_CYCLES, 16: cycles of qualified "locked and no request" before the interconnect reset releases; must be ≥1 and < 2^CNT_W.
- PERIPH_DELAY_CYCLES, 8: cycles between interconnect release and peripheral release; must be ≥1 and < 2^CNT_W.
- DEBOUNCE_CYCLES, 4: consecutive synchronised-high cycles that qualify i_ext_reset_req. Used only with the debounce macro; must be ≥1.
- CNT_W, 8: width of the sequence counter.

Ports:
- i_clk  in  1  domain clock.
- i_reset  in  1  synchronous, active-high reset.
- i_ext_reset_req  in  1  asynchronous external reset request, active-high.
- i_clk_locked  in  1  asynchronous clock-locked (MMCM/PLL) indication.
- i_sw_reset  in  1  host software reset, synchronous to i_clk, single-cycle pulse.
- o_interconnect_reset  out  1  active-high interconnect reset.
- o_interconnect_resetn  out  1  exact complement of o_interconnect_reset.
- o_peripheral_reset  out  1  active-high peripheral reset.
- o_peripheral_resetn  out  1  exact complement of o_peripheral_reset.
- o_reset_done  out  1  high only in RUN.
- o_state  out  2  current state: HOLD=0, REL_IC=1, RUN=2.

## Operation
- **Synchronisers.** i_ext_reset_req and i_clk_locked each pass through a 2-flop synchroniser.
  - On i_reset, the ext synchroniser flops load 1 and the locked synchroniser flops load 0, so the block stays in reset until the inputs are seen.
  - ext_eff is the synchronised request (or the debounced one, see Configuration).
- **Trigger.** trigger = ext_eff | ~locked_sync | i_sw_reset.
- **Counter.** A single CNT_W-bit counter `cnt` serves both timed states.
- **States:**
  - **HOLD:** both resets asserted.
    - trigger → cnt ← 0.
    - Otherwise cnt ← cnt+1.
    - When cnt == IC_HOLD_CYCLES-1 and there is no trigger → REL_IC, cnt ← 0.
  - **REL_IC:** interconnect reset released, peripheral reset still asserted.
    - trigger → HOLD, cnt ← 0.
    - Otherwise, when cnt == PERIPH_DELAY_CYCLES-1 → RUN, cnt ← 0.
    - Otherwise cnt ← cnt+1.
  - **RUN:** all resets released, o_reset_done = 1.
    - trigger → HOLD, cnt ← 0.
- **Outputs.** All outputs are dedicated flops loaded from the next-state value, so they change on the same edge as the state. There is no combinational decode glitch.
  - o_interconnect_reset = (state == HOLD).
  - o_peripheral_reset = (state != RUN).
- **Priority.** A trigger always wins over a count-complete transition in the same cycle.
- **Counter wrap.** The counter never wraps, because parameter limits guarantee a terminal count below 2^CNT_W.
- **Reset.** While i_reset is high:
  - state is HOLD and cnt is 0;
  - o_interconnect_reset = o_peripheral_reset = 1 and both resetn outputs = 0;
  - o_reset_done = 0 and o_state = 0.
  - Asserting i_reset mid-sequence returns the block to these values at the next edge.

## Timing
Edge numbering: edge 0 is the first edge with i_reset low, i_clk_locked=1 and i_ext_reset_req=0 held stable.
- locked_sync = 1 and ext_sync = 0 from edge 2. cnt = k at edge 2+k.
- Interconnect release: o_interconnect_reset falls at edge IC_HOLD_CYCLES+2 (edge 18 with defaults).
- Peripheral release: o_peripheral_reset falls and o_reset_done rises at edge IC_HOLD_CYCLES+PERIPH_DELAY_CYCLES+2 (edge 26).
- Re-assertion latency:
  - i_sw_reset sampled high at edge n → both resets asserted at edge n+1.
  - Async request or lock loss → resets asserted 3 edges after the input edge (2 synchroniser edges + 1 state edge), or 3+DEBOUNCE_CYCLES-1 edges with debounce.
- Re-release: after any trigger clears, the full sequence restarts from cnt=0. There is no partial resume.

## Configuration
- CLOCK_RESET_SEQ_DEBOUNCE_EN defined:
  - ext_eff is set only after ext_sync has been high for DEBOUNCE_CYCLES consecutive cycles.
  - ext_eff clears on the first cycle ext_sync is low.
  - The debounce counter resets with ext_eff = 1.
  - Shorter ext pulses are ignored.
- Undefined: ext_eff = ext_sync. A single synchronised high cycle triggers.

## Test plan
- Power-up with defaults, locked=1, ext=0 → interconnect reset falls at edge 18, peripheral reset falls and o_reset_done rises at edge 26, and resetn outputs are complements on every cycle.
- From RUN, i_sw_reset pulse at edge 40 → both resets = 1 and o_state = 0 at edge 41; interconnect release at edge 57, peripheral release at edge 65.
- Lock drops for 1 input cycle while in REL_IC → HOLD with cnt = 0 within 3 edges, then the full 16+8 sequence restarts.
- Count-complete in HOLD coincides with i_sw_reset → remains HOLD with cnt = 0; no REL_IC transition.
- i_reset asserted while in RUN → all outputs return to reset values at the next edge.
- ext request held high for 2 cycles from RUN → with the debounce macro (DEBOUNCE_CYCLES=4) the block stays in RUN; without it, the block enters HOLD 3 edges after the request.
